// File: rtl/cmp_pkg.sv
// Shared types and the core compare function for the stream comparator.
package cmp_pkg;

   // Widest operand the compare datapath supports; narrower operands are extended.
   localparam int unsigned CMP_MAX_W = 64;

   typedef enum logic [1:0] {
      S_EQ,
      S_LT,
      S_GT
   } cmp_state_e;

   typedef struct packed {
      logic eq;
      logic lt;
      logic gt;
   } cmp_res_t;

   // Operands arrive already extended to CMP_MAX_W (sign- or zero-extended to match signed_mode).
   function automatic cmp_res_t cmp_f(input logic [CMP_MAX_W-1:0] a,
                                      input logic [CMP_MAX_W-1:0] b,
                                      input logic                 signed_mode);
      cmp_res_t r;
      logic     less;
      r = '0;
      if (signed_mode) begin
         less = ($signed(a) < $signed(b));
      end else begin
         less = (a < b);
      end
      if (a == b) begin
         r.eq = 1'b1;
      end else if (less) begin
         r.lt = 1'b1;
      end else begin
         r.gt = 1'b1;
      end
      return r;
   endfunction

   // One-hot verdict corresponding to a frame state.
   function automatic cmp_res_t state_to_res(input cmp_state_e s);
      cmp_res_t r;
      r = '0;
      case (s)
         S_EQ:    r.eq = 1'b1;
         S_LT:    r.lt = 1'b1;
         S_GT:    r.gt = 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational WIDTH-bit compare, signed or unsigned, giving a one-hot verdict.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SIGNED = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_res_t         res
);

   logic [CMP_MAX_W-1:0] a_ext;
   logic [CMP_MAX_W-1:0] b_ext;

   // Extend both operands to the shared datapath width, then compare.
   always_comb begin
      if (SIGNED != 0) begin
         a_ext = CMP_MAX_W'($signed(a));
         b_ext = CMP_MAX_W'($signed(b));
      end else begin
         a_ext = CMP_MAX_W'(a);
         b_ext = CMP_MAX_W'(b);
      end
      res = cmp_f(a_ext, b_ext, SIGNED != 0);
   end

endmodule

// File: rtl/stream_comparator.sv
// Pipelined stream comparator: per-beat verdict plus lexicographic frame verdict
// and saturating equal-beat count, one-cycle latency, valid/ready on both sides.
module stream_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_eq,
   output logic             out_lt,
   output logic             out_gt,
   output logic             out_last,
   output logic             frame_eq,
   output logic             frame_lt,
   output logic             frame_gt,
   output logic [CNT_W-1:0] match_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   cmp_state_e       state_q, state_d, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             out_valid_q, out_valid_d;
   cmp_res_t         res_q, res_d;
   logic             last_q, last_d;
   cmp_res_t         frame_q, frame_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;

   cmp_res_t         beat;
   logic             accept;

   cmp_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_core (
      .a   (in_a),
      .b   (in_b),
      .res (beat)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Frame verdict including the current beat: the first differing beat decides, then sticks.
   always_comb begin
      state_nxt = state_q;
      if (state_q == S_EQ) begin
         if (beat.lt) begin
            state_nxt = S_LT;
         end else if (beat.gt) begin
            state_nxt = S_GT;
         end
      end
   end

   // Equal-beat count including the current beat, saturating instead of wrapping.
   always_comb begin
      cnt_inc = cnt_q;
      if (beat.eq && (cnt_q != CNT_MAX)) begin
         cnt_inc = cnt_q + CNT_W'(1);
      end
   end

   // Next-state for frame tracking and the output register.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      last_d      = last_q;
      frame_d     = frame_q;
      mcnt_d      = mcnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         res_d       = beat;
         last_d      = in_last;
         if (in_last) begin
            frame_d = state_to_res(state_nxt);
            mcnt_d  = cnt_inc;
            state_d = S_EQ;
            cnt_d   = '0;
         end else begin
            frame_d = '0;
            mcnt_d  = '0;
            state_d = state_nxt;
            cnt_d   = cnt_inc;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State register with synchronous reset; reset drops any partial frame and pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EQ;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         last_q      <= 1'b0;
         frame_q     <= '0;
         mcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         last_q      <= last_d;
         frame_q     <= frame_d;
         mcnt_q      <= mcnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_eq    = res_q.eq;
   assign out_lt    = res_q.lt;
   assign out_gt    = res_q.gt;
   assign out_last  = last_q;
   assign frame_eq  = frame_q.eq;
   assign frame_lt  = frame_q.lt;
   assign frame_gt  = frame_q.gt;
   assign match_cnt = mcnt_q;

endmodule

// File: doc/stream_comparator.md
# stream_comparator

Parametrised, pipelined successor to the team's 2-bit equality comparator. Accepts a stream of operand pairs `(a, b)` grouped into frames, and produces two results with a valid/ready handshake:
- a per-beat equal / less / greater verdict;
- at each frame's last beat, a lexicographic frame verdict and a count of equal beats.

It sits between data sources under test and the checker/scoreboard logic, replacing ad-hoc single-shot comparisons.

## Interface
- `WIDTH`, 8, operand width in bits (≥1)
- `SIGNED`, 0, 1 = two's-complement compare, 0 = unsigned
- `CNT_W`, 8, width of equal-beat counter (≥1)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `in_a`  in  WIDTH  operand A
- `in_b`  in  WIDTH  operand B
- `in_last`  in  1  beat is last of frame
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_eq` / `out_lt` / `out_gt`  out  1 each  per-beat verdict, one-hot
- `out_last`  out  1  result belongs to a last beat
- `frame_eq` / `frame_lt` / `frame_gt`  out  1 each  frame verdict, one-hot when `out_last`=1, all 0 otherwise
- `match_cnt`  out  CNT_W  equal beats in frame including this one; valid when `out_last`=1, else 0

## Operation
- **Handshake.** Input beat accepted when `in_valid && in_ready`. Result transferred when `out_valid && out_ready`.
- **Ready rule.** `in_ready = !out_valid || out_ready`, so a full-throughput stream is possible with no bubble.
- **Per-beat verdict.** `out_lt`/`out_gt` compare `in_a` against `in_b`, signed or unsigned per `SIGNED`. Exactly one of `out_eq`/`out_lt`/`out_gt` is set.
- **Frame FSM.** States `S_EQ`, `S_LT`, `S_GT`; reset state is `S_EQ`. It advances only on an accepted beat.
  - `S_EQ`: a non-equal beat moves to `S_LT` or `S_GT`. First differing beat decides, as in a lexicographic compare with beat 0 most significant.
  - `S_LT` / `S_GT`: sticky, not affected by later beats.
  - Accepted beat with `in_last`=1: the frame verdict is the next-state value, so the current beat is included. The FSM then returns to `S_EQ`.
- **Match counter.** Increments on each accepted equal beat and saturates at `2^CNT_W-1`. The output `match_cnt` includes the current beat. The counter clears to 0 after a last beat is accepted.
- **Single-beat frame.** A frame whose only beat has `in_last`=1 gives a frame verdict equal to the beat verdict; `match_cnt` is 0 or 1.
- **Holding.** While `out_valid && !out_ready`, all outputs hold stable and no input is accepted.
- **Reset mid-frame.** The partial frame is discarded: FSM returns to `S_EQ`, counter goes to 0, and any pending result is dropped.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `in_ready`=1 during the cycle after reset, all result outputs 0, `match_cnt`=0.
- Simultaneous output transfer and input accept in the same cycle: the output register reloads with the new beat, with no gap.
- `in_a`, `in_b`, and `in_last` are sampled only on accept; values while `in_ready`=0 are ignored.
- Counter wrap is not allowed; saturation is the required behaviour.

## Structure
- **Package `cmp_pkg`:**
  - `cmp_state_e` enum (`S_EQ`, `S_LT`, `S_GT`);
  - `cmp_res_t` packed struct `{eq, lt, gt}`;
  - function `cmp_res_t cmp_f(a, b, signed_mode)`.
- **Sub-module `cmp_core`:** purely combinational WIDTH/SIGNED compare producing `cmp_res_t`. It is instantiated once.
- **Top level:** holds the FSM, counter, and output register.

## Test plan
- **Single-beat frames** (WIDTH=2, SIGNED=0, `out_ready`=1): `(3,2)` → gt/gt, cnt 0; `(3,3)` → eq/eq, cnt 1; `(1,3)` → lt/lt, cnt 0; `(1,2)` → lt/lt, cnt 0.
- **Lexicographic frame** (WIDTH=8): beats `(5,5)`, `(7,9)`, `(9,1)` with last → beat verdicts eq, lt, gt; frame_lt=1, cnt=1.
- **Signed mode** (SIGNED=1, WIDTH=8): `(0xFF,0x01)` → lt. The same pair with SIGNED=0 → gt.
- **Backpressure:** `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable, no beat lost. After release, all 4 results appear in order.
- **Saturation** (CNT_W=2): 5 equal beats, last on the 5th → `match_cnt`=3, frame_eq=1.
- **Reset mid-frame:** `(4,6)` accepted, `rst` for 1 cycle, then `(2,2)` with last → frame_eq=1, cnt=1; `out_valid`=0 during and just after reset.
